// File: rtl/bus_arbiter_pkg.sv
// Shared encodings for the two-port memory bus arbiter: FSM states,
// grant identifiers and the watchdog counter sizing helper.
package bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_INSTR = 2'd1,
      ST_DATA  = 2'd2
   } state_e;

   typedef enum logic {
      GRANT_INSTR = 1'b0,
      GRANT_DATA  = 1'b1
   } grant_e;

   // Bits needed to count 0 .. t-1 (at least one bit, also when disabled).
   function automatic int unsigned wd_count_w(input int unsigned t);
      return (t < 2) ? 1 : $clog2(t);
   endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Bus-transaction watchdog: counts enabled cycles and flags expiry when the
// count reaches TIMEOUT_CYCLES-1 while still enabled. TIMEOUT_CYCLES=0 disables it.
module bus_watchdog
   import bus_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = wd_count_w(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= count_q + CW'(1);
      end
   end

   assign expired = (TIMEOUT_CYCLES != 0) && enable && (count_q == LIMIT);

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one registered memory bus between the CPU
// fetch port and the load/store port, with a watchdog abort for hung buses.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 64,
   parameter int unsigned DATA_WIDTH     = 64,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [ADDR_WIDTH-1:0]   instr_address_in,
   input  logic                    instr_read_in,
   output logic [DATA_WIDTH-1:0]   instr_read_value_out,
   output logic                    instr_ready_out,
   input  logic [ADDR_WIDTH-1:0]   data_address_in,
   input  logic                    data_read_in,
   input  logic                    data_write_in,
   input  logic [DATA_WIDTH/8-1:0] data_write_mask_in,
   input  logic [DATA_WIDTH-1:0]   data_write_value_in,
   output logic [DATA_WIDTH-1:0]   data_read_value_out,
   output logic                    data_ready_out,
   output logic [ADDR_WIDTH-1:0]   bus_address_out,
   output logic                    bus_read_out,
   output logic                    bus_write_out,
   output logic [DATA_WIDTH/8-1:0] bus_write_mask_out,
   output logic [DATA_WIDTH-1:0]   bus_write_value_out,
   input  logic [DATA_WIDTH-1:0]   bus_read_value_in,
   input  logic                    bus_ready_in,
   output logic                    timeout_out
);

   state_e state_q, state_d;
   grant_e last_grant_q;
   logic   grant_i, grant_d;
   logic   busy, done, expired;
   logic   pend_i, pend_d;

   assign pend_i = instr_read_in;
   assign pend_d = data_read_in | data_write_in;
   assign busy   = (state_q != ST_IDLE);
   assign done   = busy & (bus_ready_in | expired);

   bus_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (~busy | done),
      .enable  (busy & ~bus_ready_in),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Arbitration in IDLE; ready pulses only reach a port still requesting.
   always_comb begin
      state_d         = state_q;
      grant_i         = 1'b0;
      grant_d         = 1'b0;
      instr_ready_out = 1'b0;
      data_ready_out  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pend_d && (!pend_i || last_grant_q == GRANT_INSTR)) begin
               grant_d = 1'b1;
               state_d = ST_DATA;
            end else if (pend_i) begin
               grant_i = 1'b1;
               state_d = ST_INSTR;
            end
         end
         ST_INSTR: begin
            instr_ready_out = done & pend_i;
            if (done) state_d = ST_IDLE;
         end
         ST_DATA: begin
            data_ready_out = done & pend_d;
            if (done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A watchdog abort returns zero data because bus_ready_in is low then.
   assign instr_read_value_out = (instr_ready_out && bus_ready_in) ? bus_read_value_in : '0;
   assign data_read_value_out  = (data_ready_out && bus_ready_in) ? bus_read_value_in : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_q        <= GRANT_INSTR;
         bus_address_out     <= '0;
         bus_read_out        <= 1'b0;
         bus_write_out       <= 1'b0;
         bus_write_mask_out  <= '0;
         bus_write_value_out <= '0;
      end else if (grant_d) begin
         last_grant_q        <= GRANT_DATA;
         bus_address_out     <= data_address_in;
         bus_read_out        <= data_read_in & ~data_write_in;
         bus_write_out       <= data_write_in;
         bus_write_mask_out  <= data_write_mask_in;
         bus_write_value_out <= data_write_value_in;
      end else if (grant_i) begin
         last_grant_q        <= GRANT_INSTR;
         bus_address_out     <= instr_address_in;
         bus_read_out        <= 1'b1;
         bus_write_out       <= 1'b0;
         bus_write_mask_out  <= '0;
         bus_write_value_out <= '0;
      end else if (done) begin
         bus_read_out        <= 1'b0;
         bus_write_out       <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timeout_out <= 1'b0;
      end else if (expired) begin
         timeout_out <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (TIMEOUT_CYCLES=8): arbitration, abandoned
// requests, watchdog abort, asynchronous reset and back-to-back throughput.
module tb_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [63:0] instr_address_in;
   logic        instr_read_in;
   logic [63:0] instr_read_value_out;
   logic        instr_ready_out;
   logic [63:0] data_address_in;
   logic        data_read_in;
   logic        data_write_in;
   logic [7:0]  data_write_mask_in;
   logic [63:0] data_write_value_in;
   logic [63:0] data_read_value_out;
   logic        data_ready_out;
   logic [63:0] bus_address_out;
   logic        bus_read_out;
   logic        bus_write_out;
   logic [7:0]  bus_write_mask_out;
   logic [63:0] bus_write_value_out;
   logic [63:0] bus_read_value_in;
   logic        bus_ready_in;
   logic        timeout_out;

   int n_asserts = 0;
   int n_fail    = 0;

   always #5 clk = ~clk;

   bus_arbiter #(
      .ADDR_WIDTH(64),
      .DATA_WIDTH(64),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .instr_address_in     (instr_address_in),
      .instr_read_in        (instr_read_in),
      .instr_read_value_out (instr_read_value_out),
      .instr_ready_out      (instr_ready_out),
      .data_address_in      (data_address_in),
      .data_read_in         (data_read_in),
      .data_write_in        (data_write_in),
      .data_write_mask_in   (data_write_mask_in),
      .data_write_value_in  (data_write_value_in),
      .data_read_value_out  (data_read_value_out),
      .data_ready_out       (data_ready_out),
      .bus_address_out      (bus_address_out),
      .bus_read_out         (bus_read_out),
      .bus_write_out        (bus_write_out),
      .bus_write_mask_out   (bus_write_mask_out),
      .bus_write_value_out  (bus_write_value_out),
      .bus_read_value_in    (bus_read_value_in),
      .bus_ready_in         (bus_ready_in),
      .timeout_out          (timeout_out)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs change and outputs are sampled here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n             = 1'b0;
      instr_address_in    = '0;
      instr_read_in       = 1'b0;
      data_address_in     = '0;
      data_read_in        = 1'b0;
      data_write_in       = 1'b0;
      data_write_mask_in  = '0;
      data_write_value_in = '0;
      bus_read_value_in   = '0;
      bus_ready_in        = 1'b0;
      tick();
      tick();
      chk("rst_bus_read", bus_read_out, 0);
      chk("rst_bus_write", bus_write_out, 0);
      chk("rst_bus_addr", bus_address_out, 0);
      chk("rst_instr_ready", instr_ready_out, 0);
      chk("rst_data_ready", data_ready_out, 0);
      chk("rst_timeout", timeout_out, 0);
      reset_n = 1'b1;
      tick();

      // Lone fetch: bus_ready in the second bus cycle.
      instr_read_in    = 1'b1;
      instr_address_in = 64'h1000;
      tick();
      chk("f1_strobe", bus_read_out, 1);
      chk("f1_addr", bus_address_out, 64'h1000);
      chk("f1_wr", bus_write_out, 0);
      chk("f1_ready_early", instr_ready_out, 0);
      tick();
      bus_ready_in      = 1'b1;
      bus_read_value_in = 64'hDEAD;
      #1;
      chk("f1_ready", instr_ready_out, 1);
      chk("f1_value", instr_read_value_out, 64'hDEAD);
      chk("f1_dready", data_ready_out, 0);
      chk("f1_dvalue", data_read_value_out, 0);
      tick();
      bus_ready_in  = 1'b0;
      instr_read_in = 1'b0;
      #1;
      chk("f1_strobe_drop", bus_read_out, 0);
      chk("f1_ready_once", instr_ready_out, 0);
      tick();

      // Contention: store wins first after reset, then the fetch.
      instr_read_in       = 1'b1;
      instr_address_in    = 64'h2000;
      data_write_in       = 1'b1;
      data_address_in     = 64'h3000;
      data_write_mask_in  = 8'h0F;
      data_write_value_in = 64'h55;
      tick();
      chk("c1_write", bus_write_out, 1);
      chk("c1_read", bus_read_out, 0);
      chk("c1_addr", bus_address_out, 64'h3000);
      chk("c1_mask", bus_write_mask_out, 8'h0F);
      chk("c1_value", bus_write_value_out, 64'h55);
      bus_ready_in = 1'b1;
      #1;
      chk("c1_dready", data_ready_out, 1);
      chk("c1_iready", instr_ready_out, 0);
      tick();
      bus_ready_in  = 1'b0;
      data_write_in = 1'b0;
      #1;
      chk("c1_dead", bus_write_out | bus_read_out, 0);
      tick();
      chk("c2_read", bus_read_out, 1);
      chk("c2_addr", bus_address_out, 64'h2000);
      bus_ready_in      = 1'b1;
      bus_read_value_in = 64'h1234;
      #1;
      chk("c2_iready", instr_ready_out, 1);
      chk("c2_ivalue", instr_read_value_out, 64'h1234);
      tick();
      bus_ready_in    = 1'b0;
      data_read_in    = 1'b1;
      data_address_in = 64'h4000;
      tick();
      chk("c3_addr", bus_address_out, 64'h4000);
      chk("c3_read", bus_read_out, 1);
      bus_ready_in      = 1'b1;
      bus_read_value_in = 64'hABCD;
      #1;
      chk("c3_dready", data_ready_out, 1);
      chk("c3_dvalue", data_read_value_out, 64'hABCD);
      chk("c3_ivalue", instr_read_value_out, 0);
      tick();
      bus_ready_in = 1'b0;
      data_read_in = 1'b0;
      tick();
      chk("c4_addr", bus_address_out, 64'h2000);
      chk("c4_read", bus_read_out, 1);
      bus_ready_in = 1'b1;
      #1;
      chk("c4_iready", instr_ready_out, 1);
      tick();
      bus_ready_in  = 1'b0;
      instr_read_in = 1'b0;
      tick();

      // Abandoned fetch: the bus cycle still completes, no ready pulse.
      instr_read_in    = 1'b1;
      instr_address_in = 64'h5000;
      tick();
      chk("a1_strobe", bus_read_out, 1);
      instr_read_in = 1'b0;
      tick();
      chk("a1_strobe_held", bus_read_out, 1);
      bus_ready_in      = 1'b1;
      bus_read_value_in = 64'h7777;
      #1;
      chk("a1_no_ready", instr_ready_out, 0);
      chk("a1_no_value", instr_read_value_out, 0);
      tick();
      bus_ready_in = 1'b0;
      #1;
      chk("a1_strobe_drop", bus_read_out, 0);
      data_read_in    = 1'b1;
      data_address_in = 64'h6000;
      tick();
      chk("a2_addr", bus_address_out, 64'h6000);
      bus_ready_in      = 1'b1;
      bus_read_value_in = 64'h6666;
      #1;
      chk("a2_dready", data_ready_out, 1);
      chk("a2_dvalue", data_read_value_out, 64'h6666);
      tick();
      bus_ready_in = 1'b0;
      data_read_in = 1'b0;
      tick();

      // Watchdog: load with a silent bus aborts in the eighth bus cycle.
      data_read_in      = 1'b1;
      data_address_in   = 64'h7000;
      bus_read_value_in = 64'hFFFF;
      tick();
      chk("w1_ready_c1", data_ready_out, 0);
      repeat (6) tick();
      chk("w1_ready_c7", data_ready_out, 0);
      chk("w1_strobe_c7", bus_read_out, 1);
      tick();
      chk("w1_ready_c8", data_ready_out, 1);
      chk("w1_value_c8", data_read_value_out, 0);
      chk("w1_flag_pre", timeout_out, 0);
      tick();
      data_read_in = 1'b0;
      #1;
      chk("w1_flag", timeout_out, 1);
      chk("w1_strobe_drop", bus_read_out, 0);
      chk("w1_ready_gone", data_ready_out, 0);
      tick();
      data_read_in    = 1'b1;
      data_address_in = 64'h8000;
      tick();
      chk("w2_addr", bus_address_out, 64'h8000);
      bus_ready_in      = 1'b1;
      bus_read_value_in = 64'h8888;
      #1;
      chk("w2_dready", data_ready_out, 1);
      chk("w2_dvalue", data_read_value_out, 64'h8888);
      tick();
      bus_ready_in = 1'b0;
      data_read_in = 1'b0;
      #1;
      chk("w2_flag_sticky", timeout_out, 1);
      tick();

      // Asynchronous reset in the middle of a store.
      data_write_in       = 1'b1;
      data_address_in     = 64'h9000;
      data_write_mask_in  = 8'hF0;
      data_write_value_in = 64'h99;
      tick();
      chk("r1_write", bus_write_out, 1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("r1_write_async", bus_write_out, 0);
      chk("r1_no_ready", data_ready_out, 0);
      chk("r1_flag_clr", timeout_out, 0);
      data_write_in = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      chk("r1_idle", bus_write_out | bus_read_out, 0);
      tick();

      // Back-to-back fetches with bus_ready in the first bus cycle.
      instr_read_in     = 1'b1;
      instr_address_in  = 64'hA000;
      bus_read_value_in = 64'hA1;
      tick();
      chk("b1_strobe", bus_read_out, 1);
      bus_ready_in = 1'b1;
      #1;
      chk("b1_ready", instr_ready_out, 1);
      tick();
      instr_address_in = 64'hA008;
      #1;
      chk("b1_dead", bus_read_out, 0);
      chk("b1_idle_ignores_ready", instr_ready_out, 0);
      tick();
      chk("b2_strobe", bus_read_out, 1);
      chk("b2_addr", bus_address_out, 64'hA008);
      chk("b2_ready", instr_ready_out, 1);
      chk("b2_value", instr_read_value_out, 64'hA1);
      tick();
      bus_ready_in  = 1'b0;
      instr_read_in = 1'b0;
      #1;
      chk("b2_dead", bus_read_out, 0);
      tick();
      chk("b_end_idle", bus_read_out, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
